// File: rtl/leb128_imm_decoder.sv
// LEB128 immediate decoder: one byte per cycle, 32/64-bit, signed/unsigned.
// Define LEB_STRICT_CHECK_EN to also reject illegal unused bits in a max-length terminal byte.
module leb128_imm_decoder #(
  parameter int MAX_BYTES = 10,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             width64,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_value,
  output logic [LEN_W-1:0] out_len,
  output logic             error,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic               sgn_q;
  logic               w64_q;
  logic [63:0]        acc_q;
  logic [6:0]         shift_q;
  logic [LEN_W-1:0]   count_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [63:0]        out_value_q;
  logic [LEN_W-1:0]   out_len_q;
  logic               error_q;
  logic               busy_q;

  logic [63:0]        acc_d;
  logic [6:0]         shift_d;
  logic [LEN_W-1:0]   count_d;
  logic [63:0]        fill;
  logic [63:0]        val_w;
  logic               at_lim;
  logic               ovf;
  logic               bad_pad;

  always_comb begin
    shift_d = shift_q + 7'd7;
    count_d = count_q + LEN_W'(1);
    acc_d   = acc_q | ({57'd0, in_byte[6:0]} << shift_q);
    at_lim  = count_d == (w64_q ? LEN_W'(MAX_BYTES) : LEN_W'(5));
    ovf     = in_byte[7] & at_lim;
    bad_pad = 1'b0;
`ifdef LEB_STRICT_CHECK_EN
    if (!in_byte[7] && at_lim) begin
      unique case ({w64_q, sgn_q})
        2'b00: bad_pad = in_byte[6:4] != 3'b000;
        2'b01: bad_pad = in_byte[6:4] != {3{in_byte[3]}};
        2'b10: bad_pad = in_byte[6:1] != 6'd0;
        default: bad_pad = (in_byte[6:0] != 7'h00) &&
                           (in_byte[6:0] != 7'h7F);
      endcase
    end
`endif
    fill = '0;
    if (sgn_q && in_byte[6] &&
        shift_d < (w64_q ? 7'd64 : 7'd32))
      fill = ~64'd0 << shift_d;
    val_w = acc_d | fill;
    // 32-bit results drop everything above bit 31, then re-extend
    if (!w64_q)
      val_w = {{32{sgn_q & val_w[31]}}, val_w[31:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sgn_q       <= 1'b0;
      w64_q       <= 1'b0;
      acc_q       <= '0;
      shift_q     <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_len_q   <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sgn_q      <= signed_mode;
            w64_q      <= width64;
            acc_q      <= '0;
            shift_q    <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q   <= acc_d;
            shift_q <= shift_d;
            count_q <= count_d;
            if (!in_byte[7] || ovf) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_value_q <= val_w;
              out_len_q   <= count_d;
              error_q     <= ovf | bad_pad;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_len   = out_len_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_leb128_imm_decoder.sv
// Directed bench for leb128_imm_decoder: vector table plus hold/reset sequences.
// Expectations follow LEB_STRICT_CHECK_EN when it is defined.
module tb_leb128_imm_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic        width64;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leb128_imm_decoder dut (
    .clk(clk), .reset(reset), .start(start),
    .signed_mode(signed_mode), .width64(width64),
    .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_value(out_value),
    .out_len(out_len), .error(error), .busy(busy)
  );

  typedef struct {
    logic        sg;
    logic        w64;
    int          n;
    logic [79:0] b;
    bit          gap;
    logic [63:0] val;
    int          len;
    logic        err;
    bit          chkv;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic begin_decode(input logic sg, input logic w);
    @(negedge clk);
    start = 1'b1;
    signed_mode = sg;
    width64 = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vt[k];
    begin_decode(v.sg, v.w64);
    chk($sformatf("v%0d in_ready", k), 64'(in_ready), 64'd1);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0 && v.b[8*(i-1)+7] == 1'b0) break;
      feed(v.b[8*i +: 8], v.gap && i > 0);
    end
    chk($sformatf("v%0d out_valid", k), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d in_ready_done", k), 64'(in_ready), 64'd0);
    chk($sformatf("v%0d len", k), 64'(out_len), 64'(v.len));
    chk($sformatf("v%0d err", k), 64'(error), 64'(v.err));
    if (v.chkv)
      chk($sformatf("v%0d value", k), out_value, v.val);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d idle", k), {63'd0, busy}, 64'd0);
  endtask

  logic [63:0] hv;
  logic [3:0]  hl;

  initial begin
    vt[0]  = '{1, 1, 1, 80'h2A, 0, 64'd42, 1, 0, 1};
    vt[1]  = '{1, 1, 1, 80'h7F, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1};
    vt[2]  = '{0, 1, 3, 80'h268EE5, 1, 64'h98765, 3, 0, 1};
    vt[3]  = '{0, 0, 5, 80'h8080808080, 0, 64'h0, 5, 1, 1};
`ifdef LEB_STRICT_CHECK_EN
    vt[4]  = '{0, 0, 5, 80'h7FFFFFFFFF, 0, 64'h0, 5, 1, 0};
`else
    vt[4]  = '{0, 0, 5, 80'h7FFFFFFFFF, 0, 64'hFFFF_FFFF, 5, 0, 1};
`endif
    vt[5]  = '{1, 0, 1, 80'h7F, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1};
    vt[6]  = '{1, 0, 3, 80'h78BBC0, 0, 64'hFFFF_FFFF_FFFE_1DC0, 3, 0, 1};
    vt[7]  = '{0, 1, 10, 80'h01FFFFFFFFFFFFFFFFFF, 0,
               64'hFFFF_FFFF_FFFF_FFFF, 10, 0, 1};
    vt[8]  = '{0, 1, 10, 80'h80808080808080808080, 0, 64'h0, 10, 1, 1};
    vt[9]  = '{1, 1, 10, 80'h7FFFFFFFFFFFFFFFFFFF, 1,
               64'hFFFF_FFFF_FFFF_FFFF, 10, 0, 1};
    vt[10] = '{0, 0, 5, 80'h0FFFFFFFFF, 0, 64'hFFFF_FFFF, 5, 0, 1};
    vt[11] = '{1, 0, 5, 80'h7880808080, 0, 64'hFFFF_FFFF_8000_0000, 5, 0, 1};
    vt[12] = '{1, 1, 2, 80'h7F80, 0, 64'hFFFF_FFFF_FFFF_FF80, 2, 0, 1};

    reset = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    width64 = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst value", out_value, 64'd0);
    chk("rst len", 64'(out_len), 64'd0);
    chk("rst err", 64'(error), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);

    for (int k = 0; k < 13; k++) run_vec(k);

    // Back-pressure: result must hold and start must be ignored
    begin_decode(1'b0, 1'b1);
    feed(8'hE5, 0);
    feed(8'h8E, 0);
    feed(8'h26, 0);
    hv = out_value;
    hl = out_len;
    chk("hold value0", hv, 64'h98765);
    for (int c = 0; c < 3; c++) begin
      start = 1'b1;
      signed_mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("hold valid", 64'(out_valid), 64'd1);
      chk("hold value", out_value, hv);
      chk("hold len", 64'(out_len), 64'(hl));
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release", 64'(out_valid), 64'd0);

    // Reset partway through a decode discards everything
    begin_decode(1'b1, 1'b1);
    feed(8'hFF, 0);
    feed(8'hFF, 0);
    chk("mid busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr in_ready", 64'(in_ready), 64'd0);
    chk("mr out_valid", 64'(out_valid), 64'd0);
    chk("mr value", out_value, 64'd0);
    chk("mr len", 64'(out_len), 64'd0);
    chk("mr err", 64'(error), 64'd0);
    chk("mr busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("mr no pulse", 64'(out_valid), 64'd0);

    // Decoder must be fully usable after the abort
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
